// File: rtl/smart_alu_pkg.sv
// Shared types and default widths for the smart-bits ALU scheduler.
package smart_alu_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int OP_W_DEF  = 10;
    localparam int ALU_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SHL = 2'b01,
        OP_LE  = 2'b10,
        OP_AND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/smart_alu_core.sv
// Combinational smart-bits ALU: add, shift-left, unsigned compare, reduce-and.
module smart_alu_core
    import smart_alu_pkg::*;
#(
    parameter int OP_W  = OP_W_DEF,
    parameter int ALU_W = ALU_W_DEF
) (
    input  op_e              op,
    input  logic [ALU_W-1:0] a_ext,
    input  logic [ALU_W-1:0] b,
    input  logic [OP_W-1:0]  a_raw,
    output logic [ALU_W-1:0] result
);

    // A shift amount of ALU_W or more pushes every bit out.
    localparam logic [ALU_W-1:0] SHIFT_LIMIT = ALU_W'(ALU_W);

    // Result select; compare and reduce only drive bit 0.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a_ext + b;
            OP_SHL: result = (b >= SHIFT_LIMIT) ? '0 : (a_ext << b);
            OP_LE:  result = {{(ALU_W-1){1'b0}}, (a_ext <= b)};
            OP_AND: result = {{(ALU_W-1){1'b0}}, (&a_raw)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/smart_alu_sched.sv
// Round-robin scheduler sharing one smart-bits ALU among N_REQ requesters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for any req_valid; grants and latches operands
// ST_EXEC | ALU evaluates latched operands, result registered
// ST_RESP | result held on resp_* until resp_ready handshake
module smart_alu_sched
    import smart_alu_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int ALU_W = ALU_W_DEF
) (
    input  logic                       CLK,
    input  logic                       RESETN,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [N_REQ*OP_W-1:0]      req_a,
    input  logic [N_REQ*ALU_W-1:0]     req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(N_REQ)-1:0]   resp_id,
    output logic [ALU_W-1:0]           resp_data
);

    localparam int ID_W = $clog2(N_REQ);

    state_e           state, next_state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    op_e              op_q;
    logic [OP_W-1:0]  a_q;
    logic [ALU_W-1:0] b_q;
    logic [ALU_W-1:0] resp_data_q;
    logic [ALU_W-1:0] a_ext;
    logic [ALU_W-1:0] alu_result;
    logic [ID_W-1:0]  grant_id;
    logic             grant;

    // Rotate so ptr sits at bit 0, find the lowest set bit, rotate back.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  base);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [ID_W-1:0]    off;
        dbl = {valid, valid};
        rot = dbl[base +: N_REQ];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end
        return base + off;
    endfunction

    // Next-state, grant and handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        grant      = 1'b0;
        grant_id   = rr_pick(req_valid, ptr);
        case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant               = 1'b1;
                    req_ready[grant_id] = 1'b1;
                    next_state          = ST_EXEC;
                end
            end
            ST_EXEC: next_state = ST_RESP;
            ST_RESP: if (resp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        // Nothing is granted while reset is held, whatever the inputs say.
        if (!RESETN) begin
            req_ready = '0;
            grant     = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Operand capture on grant, result capture in EXEC, pointer advance on handshake.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ptr         <= '0;
            id_q        <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            resp_data_q <= '0;
        end else begin
            if (grant) begin
                id_q <= grant_id;
                op_q <= op_e'(req_op[2*grant_id +: 2]);
                a_q  <= req_a[grant_id*OP_W +: OP_W];
                b_q  <= req_b[grant_id*ALU_W +: ALU_W];
            end
            if (state == ST_EXEC) resp_data_q <= alu_result;
            if (state == ST_RESP && resp_ready) ptr <= id_q + ID_W'(1);
        end
    end

    assign a_ext = {{(ALU_W-OP_W){1'b0}}, a_q};

    smart_alu_core #(
        .OP_W  (OP_W),
        .ALU_W (ALU_W)
    ) u_core (
        .op     (op_q),
        .a_ext  (a_ext),
        .b      (b_q),
        .a_raw  (a_q),
        .result (alu_result)
    );

    assign resp_valid = (state == ST_RESP) && RESETN;
    assign resp_id    = id_q;
    assign resp_data  = resp_data_q;

endmodule

// File: doc/smart_alu_sched.md
# smart_alu_sched

Round-robin scheduler that time-shares one 16-bit smart-bits ALU (add, shift-left, unsigned compare, reduce-and) among several requesters. It issues a ready/valid handshake per requester and zero-extends each 10-bit operand A to the ALU width. It executes one operation at a time and returns a tagged 16-bit result on a single response channel with backpressure. It sits between the requesting datapaths and the shared arithmetic unit, replacing per-requester adders and shifters.

## Interface
- N_REQ, default 4: number of requesters (power of two, 2..8).
- OP_W, default 10: width of operand A per requester.
- ALU_W, default 16: ALU, operand B and result width (ALU_W > OP_W).
- CLK  in  1  clock; all state updates on the rising edge.
- RESETN  in  1  synchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_op  in  2*N_REQ  opcode per requester, slice i at [2i+1:2i]: 00 add, 01 shl, 10 le, 11 and-reduce.
- req_a  in  N_REQ*OP_W  operand A per requester, unsigned.
- req_b  in  N_REQ*ALU_W  operand B per requester, unsigned.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  $clog2(N_REQ)  index of the requester that owns the result.
- resp_data  out  ALU_W  result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no req_valid set: hold state; req_ready = 0.
- IDLE, any req_valid set: grant g = the first valid index at or after ptr, wrapping modulo N_REQ.
  - req_ready[g] = 1 combinationally in the same cycle.
  - Latch op, a_ext = zero-extended req_a slice, b, and id = g.
  - Go to EXEC.
- EXEC: compute and register the result into resp_data, then go to RESP. Width rules:
  - add: (a_ext + b) mod 2^ALU_W; carry-out is dropped.
  - shl: a_ext << b. Any b ≥ ALU_W yields 0.
  - le: bit 0 = (a_ext <= b); upper bits 0.
  - and-reduce: bit 0 = & of the original OP_W bits of A (not a_ext); upper bits 0.
- RESP: resp_valid = 1. resp_data and resp_id stay stable until resp_ready = 1.
  - On the handshake: ptr ← (id + 1) mod N_REQ, then go to IDLE.
- req_ready is 0 in EXEC and RESP. A requester holding req_valid waits; it is never dropped.
- A requester that deasserts req_valid before it is granted is simply not served. This is legal.
- Changes to a granted requester's inputs after its grant cycle have no effect.

## Timing
- Reset (RESETN = 0 at a rising edge):
  - state = IDLE, ptr = 0.
  - resp_valid = 0, resp_data = 0, resp_id = 0.
  - req_ready = 0 for the whole reset cycle, regardless of req_valid.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded with no response. ptr returns to 0.
- Latency: grant in cycle T, EXEC in cycle T+1, resp_valid high from T+2.
- Peak throughput: one operation per 3 cycles with resp_ready held high. The RESP→IDLE handshake cycle is not also a grant cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. Each requester waits at most N_REQ-1 operations between grants.
- Simultaneous events:
  - A new req_valid rising in the RESP handshake cycle is seen in the next IDLE cycle.
  - resp_ready high while resp_valid is low is ignored.

## Structure
- Shared package smart_alu_pkg holds:
  - the opcode enum: OP_ADD = 2'b00, OP_SHL = 2'b01, OP_LE = 2'b10, OP_AND = 2'b11;
  - the FSM state enum;
  - default width constants.
- Natural sub-module: smart_alu_core. It is purely combinational, takes (op, a_ext, b, a_raw) and produces the ALU_W result, and is instantiated once inside the scheduler.
- Round-robin pick is a local function (rotate, find-first, unrotate). No separate module.

## Test plan
- Single add: requester 2 with A = 10'h3FF, B = 16'hFFFF, op add. Expected: req_ready[2] in cycle 1; resp_valid at cycle 3 with resp_data = 16'h03FE, resp_id = 2.
- Shift edges: A = 1, op shl.
  - B = 15 → 16'h8000.
  - B = 16 → 16'h0000.
  - B = 16'hFFFF → 16'h0000.
- Compare and reduce:
  - le, A = 10'd5, B = 16'd5 → 16'h0001; B = 16'd4 → 16'h0000.
  - and-reduce, A = 10'h3FF → 16'h0001; A = 10'h3FE → 16'h0000.
- Fairness: all 4 requesters hold req_valid, resp_ready = 1. Expected: resp_id sequence is 0,1,2,3,0,1 and a new resp_valid arrives every 3 cycles.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP. Expected: resp_data and resp_id stay stable, req_ready stays 0, and no new grant occurs until the handshake.
- Reset mid-op: drive RESETN = 0 in EXEC. Expected next cycle: state IDLE, resp_valid = 0, ptr = 0, and no response for the aborted operation.
